// File: rtl/tfacc_pkg.sv
// Shared types and constants for the tfacc read path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tfacc_pkg;

   typedef logic [127:0] u128_t;

   // AXI encodings used by the read-burst engine: 16-byte beats, incrementing bursts.
   localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   // AXI bursts must not cross a 4 KB address boundary.
   localparam int BOUND_4K   = 4096;
   localparam int BEAT_BYTES = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_t;

   function automatic logic [19:0] min_u20(input logic [19:0] a, input logic [19:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/tfacc_rfifo.sv
// Synchronous read-data FIFO with occupancy count; combinational head read.
// Latency: a write is visible at the head one cycle later.
// Backpressure: writes when full and reads when empty are ignored; the producer tracks space itself.
module tfacc_rfifo
   import tfacc_pkg::*;
#(
   parameter  int DEPTH = 32,
   localparam int CW    = $clog2(DEPTH + 1)
)(
   input  logic          clk,
   input  logic          xrst,
   input  logic          i_wr_vld,
   input  logic [127:0]  i_wr_dat,
   input  logic          i_rd_rdy,
   output logic [127:0]  o_rd_dat,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   u128_t         r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_cnt;
   logic          w_wr;
   logic          w_rd;

   // Pointers wrap explicitly so non-power-of-two depths also work.
   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign w_wr     = i_wr_vld && (r_cnt != CW'(DEPTH));
   assign w_rd     = i_rd_rdy && (r_cnt != '0);
   assign o_rd_dat = r_mem[r_rptr];
   assign o_empty  = (r_cnt == '0);
   assign o_count  = r_cnt;

   // Pointer and occupancy bookkeeping; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (!xrst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_wr) r_wptr <= bump(r_wptr);
         if (w_rd) r_rptr <= bump(r_rptr);
         case ({w_wr, w_rd})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= i_wr_dat;
   end

endmodule

// File: rtl/tfacc_rd_burst.sv
// Splits a linear read command into AXI INCR bursts and streams the returned beats out in order.
// Latency: R beat to ovalid is 1 cycle when the FIFO is empty; AR issues the cycle after accept.
// Backpressure: oready stalls pop; ARs are only issued when FIFO credit for the whole burst is free.
module tfacc_rd_burst
   import tfacc_pkg::*;
#(
   parameter int MAXLEN = 16,
   parameter int FDEPTH = 2 * MAXLEN
)(
   input  logic         clk,
   input  logic         xrst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [39:0]  cmd_adr,
   input  logic [19:0]  cmd_len,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [3:0]   M00_AXI_ARID,
   output logic [39:0]  M00_AXI_ARADDR,
   output logic [7:0]   M00_AXI_ARLEN,
   output logic [2:0]   M00_AXI_ARSIZE,
   output logic [1:0]   M00_AXI_ARBURST,
   output logic         M00_AXI_ARVALID,
   input  logic         M00_AXI_ARREADY,
   input  logic [127:0] M00_AXI_RDATA,
   input  logic [1:0]   M00_AXI_RRESP,
   input  logic         M00_AXI_RLAST,
   input  logic         M00_AXI_RVALID,
   output logic         M00_AXI_RREADY,
   output logic [127:0] od,
   output logic         ovalid,
   input  logic         oready,
   output logic         olast
);

   localparam int CW = $clog2(FDEPTH + 1);

   rd_state_t     r_state;
   rd_state_t     w_state_nx;
   logic [39:0]   r_adr;
   logic [19:0]   r_rem;
   logic [19:0]   r_len;
   logic [19:0]   r_pop_cnt;
   logic [1:0]    r_outs;
   logic [CW-1:0] r_credit;
   logic          r_done;
   logic          r_err;

   logic [19:0]   w_bnd;
   logic [19:0]   w_blen;
   logic          w_accept;
   logic          w_ar_ok;
   logic          w_ar_hs;
   logic          w_r_acc;
   logic          w_pop;
   logic          w_empty;
   logic          w_full;
   logic          w_drained;
   logic [CW-1:0] w_cnt;
   logic [127:0]  w_fifo_dat;

   // Burst length: remaining beats, capped by MAXLEN and by the distance to the next 4 KB page.
   assign w_bnd  = 20'(BOUND_4K / BEAT_BYTES) - 20'(r_adr[11:4]);
   assign w_blen = min_u20(min_u20(r_rem, 20'(MAXLEN)), w_bnd);

   // Issue only with <2 bursts in flight and room reserved for every beat of this burst.
   // Both terms only improve while waiting, so ARVALID cannot drop before ARREADY.
   assign w_ar_ok   = (r_rem != '0) && (r_outs < 2'd2) && (20'(r_credit) >= w_blen);
   assign w_ar_hs   = M00_AXI_ARVALID && M00_AXI_ARREADY;
   assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
   // Beats with nothing outstanding (e.g. leftovers of a burst abandoned by reset) are dropped.
   assign w_r_acc   = M00_AXI_RVALID && (r_outs != 2'd0);
   assign w_pop     = ovalid && oready;
   assign w_full    = (w_cnt == CW'(FDEPTH));
   assign w_drained = (r_outs == 2'd0) && w_empty;

   assign M00_AXI_ARID    = 4'd0;
   assign M00_AXI_ARADDR  = r_adr;
   assign M00_AXI_ARLEN   = 8'(w_blen - 20'd1);
   assign M00_AXI_ARSIZE  = AXI_SIZE_16B;
   assign M00_AXI_ARBURST = AXI_BURST_INCR;
   assign M00_AXI_RREADY  = 1'b1;

   assign od     = w_fifo_dat;
   assign ovalid = !w_empty;
   assign olast  = ovalid && ((r_pop_cnt + 20'd1) == r_len);
   assign done   = r_done;
   assign err    = r_err;

   tfacc_rfifo #(
      .DEPTH(FDEPTH)
   ) u_rfifo (
      .clk      (clk),
      .xrst     (xrst),
      .i_wr_vld (w_r_acc),
      .i_wr_dat (M00_AXI_RDATA),
      .i_rd_rdy (w_pop),
      .o_rd_dat (w_fifo_dat),
      .o_empty  (w_empty),
      .o_count  (w_cnt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!xrst) r_state <= ST_IDLE;
      else       r_state <= w_state_nx;
   end

   // Next-state: zero-length commands never leave IDLE; RUN ends with the last AR handshake.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_IDLE:  if (cmd_valid && (cmd_len != '0)) w_state_nx = ST_RUN;
         ST_RUN:   if (w_ar_hs && (r_rem == w_blen)) w_state_nx = ST_DRAIN;
         ST_DRAIN: if (w_drained) w_state_nx = ST_IDLE;
         default:  w_state_nx = ST_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      cmd_ready       = 1'b0;
      busy            = 1'b0;
      M00_AXI_ARVALID = 1'b0;
      case (r_state)
         ST_IDLE:  cmd_ready = 1'b1;
         ST_RUN: begin
            busy            = 1'b1;
            M00_AXI_ARVALID = w_ar_ok;
         end
         ST_DRAIN: busy = 1'b1;
         default:  cmd_ready = 1'b0;
      endcase
   end

   // Command bookkeeping: address/remaining advance per burst, popped-beat count, sticky error, done pulse.
   always_ff @(posedge clk) begin
      if (!xrst) begin
         r_adr     <= '0;
         r_rem     <= '0;
         r_len     <= '0;
         r_pop_cnt <= '0;
         r_err     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= (w_accept && (cmd_len == '0)) || ((r_state == ST_DRAIN) && w_drained);
         if (w_accept) begin
            r_adr     <= cmd_adr & ~40'hF;
            r_rem     <= cmd_len;
            r_len     <= cmd_len;
            r_pop_cnt <= '0;
            r_err     <= 1'b0;
         end else begin
            if (w_ar_hs) begin
               r_adr <= r_adr + {16'd0, w_blen, 4'd0};
               r_rem <= r_rem - w_blen;
            end
            if (w_r_acc && (M00_AXI_RRESP != 2'b00)) r_err <= 1'b1;
            if (w_pop) r_pop_cnt <= r_pop_cnt + 20'd1;
         end
      end
   end

   // Bursts in flight: up on AR handshake, down on the last beat of a burst.
   always_ff @(posedge clk) begin
      if (!xrst) begin
         r_outs <= '0;
      end else begin
         case ({w_ar_hs, w_r_acc && M00_AXI_RLAST})
            2'b10:   r_outs <= r_outs + 2'd1;
            2'b01:   r_outs <= r_outs - 2'd1;
            default: r_outs <= r_outs;
         endcase
      end
   end

   // Free FIFO credit: a whole burst is reserved at AR handshake, one beat returned per pop.
   always_ff @(posedge clk) begin
      if (!xrst) begin
         r_credit <= CW'(FDEPTH);
      end else begin
         r_credit <= r_credit - (w_ar_hs ? CW'(w_blen) : '0) + (w_pop ? CW'(1) : '0);
      end
   end

   // An accepted R beat must always find room; the credit scheme makes an overflow unreachable.
   assert property (@(posedge clk) disable iff (!xrst) !(w_r_acc && w_full));

endmodule

// File: tb/tb_tfacc_rd_burst.sv
`timescale 1ns/1ps
module tb_tfacc_rd_burst;

   localparam int MAXLEN = 16;
   localparam int FDEPTH = 32;

   logic         clk;
   logic         xrst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [39:0]  cmd_adr;
   logic [19:0]  cmd_len;
   logic         busy;
   logic         done;
   logic         err;
   logic [3:0]   M00_AXI_ARID;
   logic [39:0]  M00_AXI_ARADDR;
   logic [7:0]   M00_AXI_ARLEN;
   logic [2:0]   M00_AXI_ARSIZE;
   logic [1:0]   M00_AXI_ARBURST;
   logic         M00_AXI_ARVALID;
   logic         M00_AXI_ARREADY;
   logic [127:0] M00_AXI_RDATA;
   logic [1:0]   M00_AXI_RRESP;
   logic         M00_AXI_RLAST;
   logic         M00_AXI_RVALID;
   logic         M00_AXI_RREADY;
   logic [127:0] od;
   logic         ovalid;
   logic         oready;
   logic         olast;

   tfacc_rd_burst #(.MAXLEN(MAXLEN), .FDEPTH(FDEPTH)) dut (
      .clk(clk), .xrst(xrst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr), .cmd_len(cmd_len),
      .busy(busy), .done(done), .err(err),
      .M00_AXI_ARID(M00_AXI_ARID), .M00_AXI_ARADDR(M00_AXI_ARADDR), .M00_AXI_ARLEN(M00_AXI_ARLEN),
      .M00_AXI_ARSIZE(M00_AXI_ARSIZE), .M00_AXI_ARBURST(M00_AXI_ARBURST),
      .M00_AXI_ARVALID(M00_AXI_ARVALID), .M00_AXI_ARREADY(M00_AXI_ARREADY),
      .M00_AXI_RDATA(M00_AXI_RDATA), .M00_AXI_RRESP(M00_AXI_RRESP), .M00_AXI_RLAST(M00_AXI_RLAST),
      .M00_AXI_RVALID(M00_AXI_RVALID), .M00_AXI_RREADY(M00_AXI_RREADY),
      .od(od), .ovalid(ovalid), .oready(oready), .olast(olast)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [39:0]       adr;
      int                len;
      int                stall;    // oready held low for this many cycles after accept
      int                errbeat;  // 0-based R beat returned with SLVERR, -1 for none
      int                arwait;   // ARREADY held low for this many cycles after accept
      int                nar;
      logic [2:0][39:0]  a;
      logic [2:0][7:0]   l;
      logic              experr;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   logic [39:0] ar_adr_log[$];
   int          ar_len_log[$];
   logic [39:0] bq_adr[$];
   int          bq_len[$];
   int          r_idx, out_bfm, sent, popped, n_last, done_cnt, max_out, max_fill;
   int          cyc, stall, err_beat, arwait, ar_at_stall, cur_len;
   logic [39:0] base;
   logic        pend_ar;
   logic [39:0] pend_adr;
   logic [7:0]  pend_len;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] beat_dat(input logic [39:0] a);
      return {a, 8'hC3, ~a, 8'h5A, 32'hDEADBEEF};
   endfunction

   function automatic vec_t mk(input logic [39:0] adr, input int len, input int stl, input int eb,
                               input int aw, input int nar,
                               input logic [39:0] a0, input logic [39:0] a1, input logic [39:0] a2,
                               input int l0, input int l1, input int l2, input logic e);
      vec_t v;
      v.adr = adr; v.len = len; v.stall = stl; v.errbeat = eb; v.arwait = aw; v.nar = nar;
      v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
      v.l[0] = 8'(l0); v.l[1] = 8'(l1); v.l[2] = 8'(l2);
      v.experr = e;
      return v;
   endfunction

   // One cycle of AXI slave + stream sink: outputs sampled at negedge, inputs set for the next posedge.
   task automatic tick();
      logic        arv, ovl, olst, dn;
      logic [39:0] ara;
      logic [7:0]  arl;
      logic [127:0] odat;
      @(negedge clk);
      arv = M00_AXI_ARVALID; ara = M00_AXI_ARADDR; arl = M00_AXI_ARLEN;
      ovl = ovalid; olst = olast; odat = od; dn = done;
      if (!xrst) begin
         M00_AXI_RVALID = 1'b0;
         return;
      end
      cyc++;
      oready          = (cyc > stall);
      M00_AXI_ARREADY = (cyc > arwait);
      // R channel: one beat per cycle from bursts whose AR already completed
      if (bq_adr.size() > 0) begin
         M00_AXI_RVALID = 1'b1;
         M00_AXI_RDATA  = beat_dat(bq_adr[0] + 40'(r_idx * 16));
         M00_AXI_RLAST  = (r_idx == bq_len[0] - 1);
         M00_AXI_RRESP  = (sent == err_beat) ? 2'b10 : 2'b00;
         sent++;
         if (M00_AXI_RLAST) begin
            void'(bq_adr.pop_front());
            void'(bq_len.pop_front());
            r_idx = 0;
            out_bfm--;
         end else begin
            r_idx++;
         end
      end else begin
         M00_AXI_RVALID = 1'b0;
         M00_AXI_RLAST  = 1'b0;
         M00_AXI_RRESP  = 2'b00;
      end
      // AR channel
      if (pend_ar) chk("ar_hold", {arv, ara, arl}, {1'b1, pend_adr, pend_len});
      pend_ar = arv && !M00_AXI_ARREADY;
      pend_adr = ara; pend_len = arl;
      if (arv && M00_AXI_ARREADY) begin
         chk("ar_fixed", {M00_AXI_ARID, M00_AXI_ARSIZE, M00_AXI_ARBURST}, {4'd0, 3'b100, 2'b01});
         chk("ar_4k", (int'(ara[11:0]) + (int'(arl) + 1) * 16) <= 4096, 1'b1);
         chk("ar_maxlen", int'(arl) < MAXLEN, 1'b1);
         ar_adr_log.push_back(ara);
         ar_len_log.push_back(int'(arl));
         bq_adr.push_back(ara);
         bq_len.push_back(int'(arl) + 1);
         out_bfm++;
         if (out_bfm > max_out) max_out = out_bfm;
      end
      if (cyc == stall) ar_at_stall = ar_adr_log.size();
      // Stream sink
      if (ovl && oready) begin
         chk("od", odat, beat_dat(base + 40'(popped * 16)));
         chk("olast", olst, (popped + 1) == cur_len);
         popped++;
         if (olst) n_last++;
      end
      if (sent - popped > max_fill) max_fill = sent - popped;
      if (dn) done_cnt++;
   endtask

   task automatic clear_track(input logic [39:0] adr, input int len, input int stl, input int eb, input int aw);
      ar_adr_log.delete(); ar_len_log.delete();
      popped = 0; n_last = 0; done_cnt = 0; max_out = 0; max_fill = 0; sent = 0; cyc = 0;
      stall = stl; err_beat = eb; arwait = aw; ar_at_stall = -1; pend_ar = 1'b0;
      base = adr & ~40'hF; cur_len = len;
   endtask

   task automatic run_vec(input vec_t v);
      clear_track(v.adr, v.len, v.stall, v.errbeat, v.arwait);
      chk("cmd_ready_idle", cmd_ready, 1'b1);
      cmd_adr = v.adr; cmd_len = 20'(v.len); cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("busy_run", busy, 1'b1);
      chk("err_cleared", err, 1'b0);
      for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
      chk("done_seen", done_cnt, 1);
      chk("err", err, v.experr);
      chk("busy_done", busy, 1'b0);
      repeat (4) tick();
      chk("done_once", done_cnt, 1);
      chk("n_ar", ar_adr_log.size(), v.nar);
      for (int k = 0; k < 3; k++) begin
         if (k < v.nar && k < ar_adr_log.size()) begin
            chk("ar_addr", ar_adr_log[k], v.a[k]);
            chk("ar_len", ar_len_log[k], v.l[k]);
         end
      end
      chk("beats", popped, v.len);
      chk("olast_cnt", n_last, 1);
      chk("max_outstanding", max_out <= 2, 1'b1);
      chk("fifo_fill", max_fill <= FDEPTH, 1'b1);
      if (v.stall > 0) chk("ar_in_stall", ar_at_stall, 2);
   endtask

   vec_t vecs[7];
   vec_t vfresh;
   int   pop_snap, ar_snap;

   initial begin
      xrst = 1'b0; cmd_valid = 1'b0; cmd_adr = '0; cmd_len = '0; oready = 1'b0;
      M00_AXI_ARREADY = 1'b1; M00_AXI_RDATA = '0; M00_AXI_RRESP = 2'b00;
      M00_AXI_RLAST = 1'b0; M00_AXI_RVALID = 1'b0;
      r_idx = 0; out_bfm = 0;
      clear_track(40'h0, 0, 0, -1, 0);

      //            adr         len stall err aw nar  a0          a1          a2          l0  l1  l2 err
      vecs[0] = mk(40'h1000,    40,   0,  -1, 0, 3, 40'h1000,   40'h1100,   40'h1200,   15, 15,  7, 1'b0);
      vecs[1] = mk(40'h1FC0,     8,   0,  -1, 0, 2, 40'h1FC0,   40'h2000,   40'h0,       3,  3,  0, 1'b0);
      vecs[2] = mk(40'h0,       16,   0,   4, 0, 1, 40'h0,      40'h0,      40'h0,      15,  0,  0, 1'b1);
      vecs[3] = mk(40'h3008,     3,   0,  -1, 5, 1, 40'h3000,   40'h0,      40'h0,       2,  0,  0, 1'b0);
      vecs[4] = mk(40'h0,       64, 200,  -1, 0, 4, 40'h0,      40'h100,    40'h200,    15, 15, 15, 1'b0);
      vecs[5] = mk(40'hFF0,      2,   0,  -1, 0, 2, 40'hFF0,    40'h1000,   40'h0,       0,  0,  0, 1'b0);
      vecs[6] = mk(40'h7F80,    17,   0,  -1, 0, 2, 40'h7F80,   40'h8000,   40'h0,       7,  8,  0, 1'b0);
      vfresh  = mk(40'h5000,    20,   0,  -1, 0, 2, 40'h5000,   40'h5100,   40'h0,      15,  3,  0, 1'b0);

      // Reset state
      repeat (3) tick();
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_arvalid", M00_AXI_ARVALID, 1'b0);
      chk("rst_ovalid", ovalid, 1'b0);
      chk("rst_olast", olast, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      xrst = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Zero-length command: done one cycle after accept, never busy, no AR
      clear_track(40'h9000, 0, 0, -1, 0);
      cmd_adr = 40'h9000; cmd_len = 20'd0; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("zl_done", done, 1'b1);
      chk("zl_busy", busy, 1'b0);
      chk("zl_cmd_ready", cmd_ready, 1'b1);
      tick();
      chk("zl_done_off", done, 1'b0);
      repeat (4) tick();
      chk("zl_no_ar", ar_adr_log.size(), 0);
      chk("zl_done_cnt", done_cnt, 1);

      // Reset in the middle of a 32-beat command, while beat 10 is presented
      clear_track(40'h8000, 32, 0, -1, 0);
      cmd_adr = 40'h8000; cmd_len = 20'd32; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 500 && popped < 9; i++) tick();
      chk("mid_reached", popped, 9);
      xrst = 1'b0;
      bq_adr.delete(); bq_len.delete(); r_idx = 0; out_bfm = 0;
      tick();
      chk("mid_arvalid", M00_AXI_ARVALID, 1'b0);
      chk("mid_ovalid", ovalid, 1'b0);
      chk("mid_busy", busy, 1'b0);
      chk("mid_cmd_ready", cmd_ready, 1'b1);
      xrst = 1'b1;
      pop_snap = popped; ar_snap = ar_adr_log.size();
      repeat (6) tick();
      chk("mid_no_ar", ar_adr_log.size(), ar_snap);
      chk("mid_no_pop", popped, pop_snap);
      run_vec(vfresh);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
